// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package instr_encoder_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned FMT_W = 3;
   localparam int unsigned OPC_W = 7;
   localparam int unsigned REG_W = 5;
   localparam int unsigned F3_W  = 3;

   // Immediate format codes, shared with the decoder's immed_sel.
   typedef enum logic [FMT_W-1:0] {
      FMT_I = 3'b000,
      FMT_S = 3'b001,
      FMT_B = 3'b010,
      FMT_J = 3'b011,
      FMT_U = 3'b100
   } imm_fmt_e;

   localparam logic [OPC_W-1:0] OP_LOAD   = 7'h03;
   localparam logic [OPC_W-1:0] OP_IMM    = 7'h13;
   localparam logic [OPC_W-1:0] OP_AUIPC  = 7'h17;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'h23;
   localparam logic [OPC_W-1:0] OP_LUI    = 7'h37;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'h67;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'h6F;

   localparam logic [XLEN-1:0] ILLEGAL_WORD = 32'hDEAD_BEEF;

   // One encode request; fmt kept as raw bits so illegal codes survive to the checker.
   typedef struct packed {
      logic [FMT_W-1:0] fmt;
      logic [OPC_W-1:0] opcode;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [F3_W-1:0]  funct3;
      logic [XLEN-1:0]  imm;
   } enc_req_t;

   // True when v[31:lsb] are all copies of the same bit (value fits as signed).
   function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned lsb);
      logic [XLEN-1:0] hi;
      hi = XLEN'($signed(v) >>> lsb);
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle between the program loader and the encoder.
interface instr_encoder_if
   import instr_encoder_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned ERR_W  = 16
) ();

   logic              in_valid;
   logic              in_ready;
   logic [FMT_W-1:0]  in_fmt;
   logic [OPC_W-1:0]  in_opcode;
   logic [REG_W-1:0]  in_rd;
   logic [REG_W-1:0]  in_rs1;
   logic [REG_W-1:0]  in_rs2;
   logic [F3_W-1:0]   in_funct3;
   logic [XLEN-1:0]   in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_instr;
   logic              out_err;
   logic [ADDR_W-1:0] out_addr;
   logic [ERR_W-1:0]  err_cnt;

   modport master (
      output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_err, out_addr, err_cnt
   );

   modport slave (
      input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_err, out_addr, err_cnt
   );

endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational field packing and immediate range check for one request.
module instr_encoder_imm_pack
   import instr_encoder_pkg::*;
(
   input  enc_req_t        req,
   output logic [XLEN-1:0] instr_c,
   output logic            err_c
);

   // Pack by format; out-of-range immediates are still packed (truncated) and flagged.
   always_comb begin
      instr_c = ILLEGAL_WORD;
      err_c   = 1'b1;
      case (req.fmt)
         FMT_I: begin
            instr_c = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            err_c   = !fits_signed(req.imm, 11);
         end
         FMT_S: begin
            instr_c = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
            err_c   = !fits_signed(req.imm, 11);
         end
         FMT_B: begin
            instr_c = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                       req.imm[4:1], req.imm[11], req.opcode};
            err_c   = !fits_signed(req.imm, 12) || req.imm[0];
         end
         FMT_J: begin
            instr_c = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                       req.rd, req.opcode};
            err_c   = !fits_signed(req.imm, 20) || req.imm[0];
         end
         FMT_U: begin
            instr_c = {req.imm[31:12], req.rd, req.opcode};
            err_c   = (req.imm[11:0] != 12'h000);
         end
         default: begin
            instr_c = ILLEGAL_WORD;
            err_c   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I encoder emitting words with sequential imem addresses.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned ERR_W     = 16
) (
   input logic            clk,
   input logic            rst_n,
   input logic            clr,
   instr_encoder_if.slave bus
);

   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(4);

   enc_req_t          s1_q;
   logic              s1_v;
   logic              s2_v;
   logic [XLEN-1:0]   s2_instr;
   logic              s2_err;
   logic [ADDR_W-1:0] addr_q;
   logic [ERR_W-1:0]  err_cnt_q;

   logic              s2_free_c;
   logic              s1_adv_c;
   logic              in_rdy_c;
   logic              in_hs_c;
   logic              out_hs_c;
   logic [XLEN-1:0]   pack_instr_c;
   logic              pack_err_c;
   enc_req_t          in_req_c;

   // Handshake and stage-advance conditions; a stage moves when the next one is empty or draining.
   assign s2_free_c = !s2_v || bus.out_ready;
   assign s1_adv_c  = s1_v && s2_free_c;
   assign in_rdy_c  = rst_n && !clr && (!s1_v || s2_free_c);
   assign in_hs_c   = bus.in_valid && in_rdy_c;
   assign out_hs_c  = s2_v && bus.out_ready && !clr;

   assign in_req_c = '{fmt:    bus.in_fmt,
                       opcode: bus.in_opcode,
                       rd:     bus.in_rd,
                       rs1:    bus.in_rs1,
                       rs2:    bus.in_rs2,
                       funct3: bus.in_funct3,
                       imm:    bus.in_imm};

   // Stage 1: capture the accepted request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s1_q <= '0;
      end else if (clr) begin
         s1_v <= 1'b0;
      end else if (in_hs_c) begin
         s1_v <= 1'b1;
         s1_q <= in_req_c;
      end else if (s1_adv_c) begin
         s1_v <= 1'b0;
      end
   end

   instr_encoder_imm_pack u_imm_pack (
      .req     (s1_q),
      .instr_c (pack_instr_c),
      .err_c   (pack_err_c)
   );

   // Stage 2: hold the packed word until the consumer takes it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_v     <= 1'b0;
         s2_instr <= '0;
         s2_err   <= 1'b0;
      end else if (clr) begin
         s2_v <= 1'b0;
      end else if (s1_adv_c) begin
         s2_v     <= 1'b1;
         s2_instr <= pack_instr_c;
         s2_err   <= pack_err_c;
      end else if (out_hs_c) begin
         s2_v <= 1'b0;
      end
   end

   // Address advances only for good words; errored words reuse the current slot.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         addr_q <= BASE_A;
      end else if (out_hs_c && !s2_err) begin
         addr_q <= addr_q + WORD_INC;
      end
   end

   // Saturating count of errored words delivered.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         err_cnt_q <= '0;
      end else if (out_hs_c && s2_err && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
   end

   assign bus.in_ready  = in_rdy_c;
   assign bus.out_valid = s2_v;
   assign bus.out_instr = s2_instr;
   assign bus.out_err   = s2_err;
   assign bus.out_addr  = addr_q;
   assign bus.err_cnt   = err_cnt_q;

endmodule
